gate_tt_checker: RTL and testbench

GATE_TT_CHECKER -- requirements
Module: gate_tt_checker

---
 rtl/gate_tt_checker_pkg.sv | 26 ++
 rtl/gate_tt_checker_gate_ref.sv | 28 ++
 rtl/gate_tt_checker.sv | 130 +++++++++++++
 tb/tb_gate_tt_checker.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/gate_tt_checker_pkg.sv
// Shared definitions for the truth-table checker: gate opcode encodings,
// FSM state type, vector-count constant and an opcode legality helper.
package gate_tt_checker_pkg;

    // Gate-under-test opcodes; 6 and 7 are not assigned to any gate.
    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_NAND = 3'd1;
    localparam logic [2:0] OP_OR   = 3'd2;
    localparam logic [2:0] OP_NOR  = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_XNOR = 3'd5;

    // A two-input gate has four input combinations.
    localparam int unsigned NUM_VECTORS = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic op_is_legal(input logic [2:0] op);
        return (op <= OP_XNOR);
    endfunction

endpackage

// File: rtl/gate_tt_checker_gate_ref.sv
// gate_ref: combinational golden model of the selectable two-input gate.
// Ports:
//   op    - gate opcode (AND, NAND, OR, NOR, XOR, XNOR; others give 0)
//   a, b  - gate inputs
//   y_exp - expected gate output
module gate_ref
    import gate_tt_checker_pkg::*;
(
    input  logic [2:0] op,
    input  logic       a,
    input  logic       b,
    output logic       y_exp
);

    always_comb begin
        y_exp = 1'b0;
        case (op)
            OP_AND:  y_exp =   a & b;
            OP_NAND: y_exp = ~(a & b);
            OP_OR:   y_exp =   a | b;
            OP_NOR:  y_exp = ~(a | b);
            OP_XOR:  y_exp =   a ^ b;
            OP_XNOR: y_exp = ~(a ^ b);
            default: y_exp = 1'b0;
        endcase
    end

endmodule

// File: rtl/gate_tt_checker.sv
// gate_tt_checker: walks a two-input gate under test through all four input
// vectors, holds each for SETTLE_CYCLES+1 cycles, samples the response in the
// last cycle and compares it with the reference gate for the latched opcode.
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   start, op    - run request (honoured only in IDLE) and gate opcode
//   dut_a, dut_b - stimulus to the gate under test (0 outside RUN)
//   dut_y        - gate-under-test response
//   busy, done   - run in progress / one-cycle completion pulse
//   pass         - last run had no mismatches
//   fail_vec     - bit i set when vector {a,b}=i mismatched
//   err_count    - number of mismatching vectors (0..4)
module gate_tt_checker
    import gate_tt_checker_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [2:0] op,
    output logic       dut_a,
    output logic       dut_b,
    input  logic       dut_y,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] fail_vec,
    output logic [2:0] err_count
);

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES);
    localparam logic [1:0] LAST_VEC    = 2'(NUM_VECTORS - 1);
    localparam logic [2:0] ALL_ERR     = 3'(NUM_VECTORS);

    state_t     state;
    state_t     state_nxt;
    logic [2:0] op_lat;
    logic [1:0] vec_idx;
    logic [3:0] settle_cnt;
    logic       y_exp;
    logic       accept;
    logic       sample;
    logic       mismatch;
    logic [2:0] err_next;

    gate_ref u_gate_ref (
        .op    (op_lat),
        .a     (vec_idx[1]),
        .b     (vec_idx[0]),
        .y_exp (y_exp)
    );

    assign accept   = (state == ST_IDLE) && start;
    assign sample   = (state == ST_RUN) && (settle_cnt == SETTLE_LAST);
    assign mismatch = sample && (dut_y != y_exp);
    assign err_next = err_count + {2'b00, mismatch};

    // Stimulus is forced low outside RUN so the gate sees a quiet input.
    assign dut_a = (state == ST_RUN) && vec_idx[1];
    assign dut_b = (state == ST_RUN) && vec_idx[0];
    assign busy  = (state != ST_IDLE);
    assign done  = (state == ST_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                // An illegal opcode skips RUN and reports a total failure.
                if (start) begin
                    state_nxt = op_is_legal(op) ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                if (sample && (vec_idx == LAST_VEC)) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_lat     <= OP_AND;
            vec_idx    <= '0;
            settle_cnt <= '0;
            fail_vec   <= '0;
            err_count  <= '0;
            pass       <= 1'b0;
        end else if (accept) begin
            op_lat     <= op;
            vec_idx    <= '0;
            settle_cnt <= '0;
            pass       <= 1'b0;
            if (op_is_legal(op)) begin
                fail_vec  <= '0;
                err_count <= '0;
            end else begin
                fail_vec  <= 4'hF;
                err_count <= ALL_ERR;
            end
        end else if (state == ST_RUN) begin
            if (sample) begin
                settle_cnt         <= '0;
                fail_vec[vec_idx]  <= fail_vec[vec_idx] | mismatch;
                err_count          <= err_next;
                // pass is settled together with the last sample so it is
                // valid in the same cycle that done rises.
                if (vec_idx == LAST_VEC) begin
                    pass <= (err_next == 3'd0);
                end else begin
                    vec_idx <= vec_idx + 2'd1;
                end
            end else begin
                settle_cnt <= settle_cnt + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_gate_tt_checker.sv
module tb_gate_tt_checker;

    typedef struct {
        int         done_at;
        logic       pass;
        logic [3:0] fv;
        logic [2:0] err;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start0 = 1'b0, start1 = 1'b0;
    logic [2:0] op0 = 3'd0, op1 = 3'd0;
    logic       a0, b0, y0, busy0, done0, pass0;
    logic       a1, b1, y1, busy1, done1, pass1;
    logic [3:0] fv0, fv1;
    logic [2:0] err0, err1;
    logic       mode = 1'b0;   // 0: NAND gate connected, 1: output stuck at 1

    int n_cmp = 0;
    int n_bad = 0;
    int edge_cnt = 0;
    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    assign y0 = mode ? 1'b1 : ~(a0 & b0);
    assign y1 = mode ? 1'b1 : ~(a1 & b1);

    gate_tt_checker #(.SETTLE_CYCLES(2)) u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .op(op0),
        .dut_a(a0), .dut_b(b0), .dut_y(y0),
        .busy(busy0), .done(done0), .pass(pass0),
        .fail_vec(fv0), .err_count(err0)
    );

    gate_tt_checker #(.SETTLE_CYCLES(0)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .op(op1),
        .dut_a(a1), .dut_b(b1), .dut_y(y1),
        .busy(busy1), .done(done1), .pass(pass1),
        .fail_vec(fv1), .err_count(err1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic logic gate_fn(input logic [2:0] o, input logic a, input logic b);
        case (o)
            3'd0:    return a & b;
            3'd1:    return ~(a & b);
            3'd2:    return a | b;
            3'd3:    return ~(a | b);
            3'd4:    return a ^ b;
            3'd5:    return ~(a ^ b);
            default: return 1'b0;
        endcase
    endfunction

    function automatic exp_t model(input logic [2:0] o, input int settle, input int acc, input logic m);
        exp_t e;
        logic a, b, y;
        e.fv = 4'h0;
        e.err = 3'd0;
        if (o > 3'd5) begin
            e.fv = 4'hF;
            e.err = 3'd4;
            e.done_at = acc;
        end else begin
            for (int i = 0; i < 4; i++) begin
                a = i[1];
                b = i[0];
                y = m ? 1'b1 : ~(a & b);
                if (y != gate_fn(o, a, b)) begin
                    e.fv[i] = 1'b1;
                    e.err = e.err + 3'd1;
                end
            end
            e.done_at = acc + 4 * (settle + 1);
        end
        e.pass = (e.err == 3'd0);
        return e;
    endfunction

    // Scoreboard: every done pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        if (done0) begin
            if (q0.size() == 0) check("spurious_done0", 1, 0);
            else begin
                e0 = q0.pop_front();
                check("done_cycle0", edge_cnt, e0.done_at);
                check("pass0", pass0, e0.pass);
                check("fail_vec0", fv0, e0.fv);
                check("err_count0", err0, e0.err);
            end
        end
        if (done1) begin
            if (q1.size() == 0) check("spurious_done1", 1, 0);
            else begin
                e1 = q1.pop_front();
                check("done_cycle1", edge_cnt, e1.done_at);
                check("pass1", pass1, e1.pass);
                check("fail_vec1", fv1, e1.fv);
                check("err_count1", err1, e1.err);
            end
        end
    end

    task automatic launch(input int inst, input logic [2:0] o, input bit hold);
        int acc;
        @(negedge clk);
        if (inst == 0) begin op0 = o; start0 = 1'b1; end
        else           begin op1 = o; start1 = 1'b1; end
        @(posedge clk);
        #1;
        if (!hold) begin start0 = 1'b0; start1 = 1'b0; end
        acc = edge_cnt;
        if (inst == 0) q0.push_back(model(o, 2, acc, mode));
        else           q1.push_back(model(o, 0, acc, mode));
    endtask

    task automatic wait_idle(input int inst);
        bit ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if ((inst == 0 ? busy0 : busy1) == 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        check("idle_timeout", ok, 1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_busy", busy0, 0);
        check("rst_done", done0, 0);
        check("rst_pass", pass0, 0);
        check("rst_fail_vec", fv0, 0);
        check("rst_err", err0, 0);
        check("rst_ab", {a0, b0}, 0);

        // NAND gate, NAND opcode: vector walk 00,01,10,11 each 3 cycles.
        launch(0, 3'd1, 0);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            check("vec_seq", {a0, b0}, (k - 1) / 3);
            check("busy_run", busy0, 1);
        end
        wait_idle(0);
        check("idle_ab", {a0, b0}, 0);

        // NAND gate checked as AND: every vector mismatches.
        launch(0, 3'd0, 0);
        wait_idle(0);

        // Stuck-at-1 output checked as NAND: only vector 3 mismatches.
        mode = 1'b1;
        launch(0, 3'd1, 0);
        wait_idle(0);
        mode = 1'b0;

        // Illegal opcode: no stimulus, immediate failure report.
        launch(0, 3'd7, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("illegal_ab", {a0, b0}, 0);
        end
        wait_idle(0);

        // start held through the run and DONE, op changed mid-run.
        launch(0, 3'd1, 1);
        repeat (5) @(negedge clk);
        op0 = 3'd0;
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 50; i++) begin
                @(negedge clk);
                if (done0) begin seen = 1'b1; break; end
            end
            check("hold_done_seen", seen, 1);
        end
        @(posedge clk);
        #1 start0 = 1'b0;
        repeat (3) @(negedge clk);
        check("no_rerun_busy", busy0, 0);

        // Reset during vector 2 aborts without a done pulse.
        op0 = 3'd1;
        launch(0, 3'd1, 0);
        repeat (7) @(negedge clk);
        check("abort_vec2", {a0, b0}, 2);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        q0.delete();
        check("abort_busy", busy0, 0);
        check("abort_done", done0, 0);
        check("abort_pass", pass0, 0);
        check("abort_fail_vec", fv0, 0);
        check("abort_err", err0, 0);
        check("abort_ab", {a0, b0}, 0);
        launch(0, 3'd1, 0);
        wait_idle(0);

        // Reset and start in the same cycle: start discarded.
        @(negedge clk);
        start0 = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        #1 start0 = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check("rst_start_busy", busy0, 0);

        // SETTLE_CYCLES=0 instance: NAND passes, XOR fails only vector 0.
        launch(1, 3'd1, 0);
        wait_idle(1);
        launch(1, 3'd4, 0);
        wait_idle(1);

        repeat (3) @(negedge clk);
        check("sb_drain0", q0.size(), 0);
        check("sb_drain1", q1.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
